// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the LED sequence player: state encoding (also shown on
// the debug hex display) and a ceil-log2 helper used to size the slot timer.
package exibe_sequencia_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    BUSCA   = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    FIM     = 4'd4
  } estado_t;

  // Bits needed to hold values 0..valor-1; never returns less than 1.
  function automatic int clog2_f(input int valor);
    int w;
    int v;
    w = 0;
    v = valor - 1;
    while (v > 0) begin
      w++;
      v = v >>> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Control, memory read port and display signals of the sequence player. The
// master side (control unit, memory, board) drives requests and read data.
interface exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              zera;
  logic [ADDR_W-1:0] rodada;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_dado;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  modport master (
    output iniciar, zera, rodada, mem_dado,
    input  mem_endereco, leds, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, zera, rodada, mem_dado,
    output mem_endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia_contador_tempo.sv
// Loadable down-counter timing the lit and dark slots; fim flags count==0.
// Load has priority over counting, and the count holds at zero.
module contador_tempo #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  input  logic         conta,
  output logic         fim
);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (carrega) begin
      contagem_d = valor;
    end else if (conta && (contagem_q != '0)) begin
      contagem_d = contagem_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign fim = (contagem_q == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays memory words 0..rodada on the LEDs, each lit T_ON cycles then dark T_OFF
// cycles (1+T_ON+T_OFF per element); iniciar is ignored while busy, zera aborts.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int T_ON   = 500,
  parameter int T_OFF  = 250
) (
  input logic              clock,
  input logic              reset,
  exibe_sequencia_if.slave io
);

  localparam int TW = clog2_f(((T_ON > T_OFF) ? T_ON : T_OFF) + 1);
  localparam logic [TW-1:0] CARGA_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] CARGA_OFF = TW'(T_OFF - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic [DATA_W-1:0] led_q, led_d;

  logic          carrega;
  logic [TW-1:0] valor;
  logic          conta;
  logic          fim_tempo;

  contador_tempo #(.W(TW)) u_tempo (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (valor),
    .conta   (conta),
    .fim     (fim_tempo)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    led_d      = led_q;
    carrega    = 1'b0;
    valor      = '0;
    conta      = 1'b0;

    if (io.zera) begin
      estado_d = INICIAL;
    end else begin
      case (estado_q)
        INICIAL: begin
          if (io.iniciar) begin
            rodada_d   = io.rodada;
            endereco_d = '0;
            estado_d   = BUSCA;
          end
        end
        BUSCA: begin
          led_d    = io.mem_dado;
          carrega  = 1'b1;
          valor    = CARGA_ON;
          estado_d = ACENDE;
        end
        ACENDE: begin
          conta = 1'b1;
          if (fim_tempo) begin
            carrega  = 1'b1;
            valor    = CARGA_OFF;
            estado_d = APAGA;
          end
        end
        APAGA: begin
          conta = 1'b1;
          if (fim_tempo) begin
            // Compare before incrementing so the address stops at rodada and never wraps.
            if (endereco_q == rodada_q) begin
              estado_d = FIM;
            end else begin
              endereco_d = endereco_q + ADDR_W'(1);
              estado_d   = BUSCA;
            end
          end
        end
        FIM: begin
          estado_d = INICIAL;
        end
        default: begin
          estado_d = INICIAL;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      endereco_q <= '0;
      rodada_q   <= '0;
      led_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      led_q      <= led_d;
    end
  end

  // An abort arriving in FIM cancels the completion pulse in that same cycle.
  assign io.pronto       = (estado_q == FIM) && !io.zera;
  assign io.leds         = (estado_q == ACENDE) ? led_q : '0;
  assign io.ocupado      = (estado_q != INICIAL);
  assign io.mem_endereco = endereco_q;
  assign io.db_estado    = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Randomized and directed scoreboard bench for exibe_sequencia with T_ON=4, T_OFF=2.
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int SLOT  = 1 + T_ON + T_OFF;

  typedef struct {
    logic [3:0] leds;
    logic [3:0] addr;
    logic       pronto;
    logic [3:0] st;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [3:0] mem [16];

  int   tests;
  int   failed;
  int   cyc;
  int   start_cyc;
  int   pronto_cyc;
  int   pronto_cnt;
  exp_t exp_q[$];

  exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) io ();

  exibe_sequencia #(
    .ADDR_W (4),
    .DATA_W (4),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  assign io.mem_dado = mem[io.mem_endereco];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy cycle consumes one expected display entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (io.pronto) begin
        pronto_cnt++;
        pronto_cyc = cyc;
      end
      if (io.ocupado) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_busy", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("leds", int'(io.leds), int'(e.leds));
          chk("mem_endereco", int'(io.mem_endereco), int'(e.addr));
          chk("pronto", int'(io.pronto), int'(e.pronto));
          chk("db_estado", int'(io.db_estado), int'(e.st));
        end
      end else if (io.pronto) begin
        chk("pronto_while_idle", 1, 0);
      end
    end
  end

  // Reference: one fetch cycle, T_ON lit cycles, T_OFF dark cycles per element, then one end cycle.
  task automatic push_model(input int r, input bit abort_at_end);
    exp_t e;
    for (int k = 0; k <= r; k++) begin
      e.addr = 4'(k);
      e.pronto = 1'b0;
      e.leds = 4'd0;
      e.st = 4'd1;
      exp_q.push_back(e);
      e.leds = mem[k];
      e.st = 4'd2;
      repeat (T_ON) exp_q.push_back(e);
      e.leds = 4'd0;
      e.st = 4'd3;
      repeat (T_OFF) exp_q.push_back(e);
    end
    e.addr = 4'(r);
    e.leds = 4'd0;
    e.pronto = !abort_at_end;
    e.st = 4'd4;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (!io.ocupado) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  // mode 0: plain run; 1: zera during the end cycle; 2: rodada change and iniciar while busy.
  task automatic run_seq(input int r, input int mode);
    io.rodada = 4'(r);
    push_model(r, mode == 1);
    pronto_cnt = 0;
    io.iniciar = 1'b1;
    @(posedge clock);
    #1;
    io.iniciar = 1'b0;
    start_cyc = cyc;
    if (mode == 1) begin
      wait_cycles((r + 1) * SLOT);
      io.zera = 1'b1;
      wait_cycles(1);
      io.zera = 1'b0;
      chk("zera_fim_ocupado", int'(io.ocupado), 0);
      chk("zera_fim_estado", int'(io.db_estado), 0);
    end else if (mode == 2) begin
      wait_cycles(2);
      io.rodada = 4'd0;
      wait_cycles(3);
      io.iniciar = 1'b1;
      wait_cycles(1);
      io.iniciar = 1'b0;
    end
    wait_idle((r + 1) * SLOT + 6);
    chk("queue_drained", exp_q.size(), 0);
    chk("pronto_count", pronto_cnt, (mode == 1) ? 0 : 1);
    if (mode != 1 && pronto_cnt == 1)
      chk("pronto_latency", pronto_cyc - start_cyc + 1, (r + 1) * SLOT + 1);
    exp_q.delete();
  endtask

  initial begin : stimulus
    int r;
    tests = 0;
    failed = 0;
    pronto_cnt = 0;
    pronto_cyc = 0;
    start_cyc = 0;
    reset = 1'b0;
    io.iniciar = 1'b0;
    io.zera = 1'b0;
    io.rodada = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_leds", int'(io.leds), 0);
    chk("rst_ocupado", int'(io.ocupado), 0);
    chk("rst_pronto", int'(io.pronto), 0);
    chk("rst_mem_endereco", int'(io.mem_endereco), 0);
    chk("rst_db_estado", int'(io.db_estado), 0);
    reset = 1'b1;
    wait_cycles(1);

    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
    run_seq(2, 0);

    mem[0] = 4'd8;
    run_seq(0, 0);

    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run_seq(15, 0);

    mem[0] = 4'd3; mem[1] = 4'd5; mem[2] = 4'd9;
    run_seq(2, 2);

    // Asynchronous reset in the middle of the second lit slot.
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4;
    io.rodada = 4'd2;
    push_model(2, 1'b0);
    pronto_cnt = 0;
    io.iniciar = 1'b1;
    @(posedge clock);
    #1;
    io.iniciar = 1'b0;
    wait_cycles(9);
    reset = 1'b0;
    #1;
    chk("async_rst_leds", int'(io.leds), 0);
    chk("async_rst_ocupado", int'(io.ocupado), 0);
    chk("async_rst_db_estado", int'(io.db_estado), 0);
    chk("async_rst_mem_endereco", int'(io.mem_endereco), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_cycles(1);
    chk("async_rst_no_pronto", pronto_cnt, 0);
    run_seq(2, 0);

    mem[0] = 4'd6; mem[1] = 4'd7;
    run_seq(1, 1);

    io.zera = 1'b1;
    io.iniciar = 1'b1;
    wait_cycles(1);
    io.zera = 1'b0;
    io.iniciar = 1'b0;
    chk("zera_iniciar_ocupado", int'(io.ocupado), 0);
    chk("zera_iniciar_estado", int'(io.db_estado), 0);
    wait_cycles(2);
    chk("zera_iniciar_still_idle", int'(io.ocupado), 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      run_seq(r, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
